// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 shift-add multiplier that borrows the execute-stage ALU.
// Passes ex_* straight to the ALU while idle; owns the ALU (busy=1) otherwise.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             busy,
  input  logic [3:0]       ex_alucontrol,
  input  logic [WIDTH-1:0] ex_rs1,
  input  logic [WIDTH-1:0] ex_rs2,
  output logic [3:0]       alu_alucontrol,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [4:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            mcand_q <= op_a;
            lo_q    <= op_b;
            hi_q    <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Shift the 65-bit {carry, sum, lo} right by one each iteration.
          hi_q  <= {alu_carry, alu_result[WIDTH-1:1]};
          lo_q  <= {alu_result[0], lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DONE;
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_alucontrol = ex_alucontrol;
    alu_rs1        = ex_rs1;
    alu_rs2        = ex_rs2;
    if (state_q != IDLE) begin
      alu_alucontrol = ALU_ADD;
      alu_rs1        = hi_q;
      alu_rs2        = (state_q == RUN && lo_q[0]) ? mcand_q : '0;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign res_lo      = lo_q;
  assign res_hi      = hi_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU, products checked
// against plain 64-bit multiplication.
module tb_alu_mul_seq;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready;
  logic [31:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [31:0] res_lo, res_hi;
  logic        busy;
  logic [3:0]  ex_alucontrol, alu_alucontrol;
  logic [31:0] ex_rs1, ex_rs2, alu_rs1, alu_rs2, alu_result;
  logic        alu_carry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lo(res_lo), .res_hi(res_hi), .busy(busy),
    .ex_alucontrol(ex_alucontrol), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .alu_alucontrol(alu_alucontrol), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // Shared single-cycle ALU
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_alucontrol)
      ALU_ADD: {alu_carry, alu_result} = {1'b0, alu_rs1} + {1'b0, alu_rs2};
      ALU_SUB: alu_result = alu_rs1 - alu_rs2;
      default: alu_result = alu_rs1 ^ alu_rs2;
    endcase
  end

  // Caller is at a negedge in IDLE. Returns cycles from accept edge to res_valid
  // (41 on timeout) and the product seen; leaves the DUT in DONE.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] prod);
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    lat = 0;
    while (!res_valid && lat <= 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    prod = {res_hi, res_lo};
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({start_ready, busy, res_valid} !== 3'b100 || {res_hi, res_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/busy/vld=%b res=%h required 100 / 0",
               {start_ready, busy, res_valid}, {res_hi, res_lo});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'd3, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h00010000};
    logic [31:0] vb [5] = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'h12345678, 32'h00010000};
    logic [63:0] exp_p [5] = '{64'd15, 64'hFFFFFFFE_00000001, 64'h1_00000000,
                               64'd0, 64'h1_00000000};
    int lat;
    logic [63:0] p;
    for (int i = 0; i < 5; i++) begin
      mul_op(va[i], vb[i], lat, p);
      n_checks++;
      if (lat !== 32) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d cycles required 32", i, lat);
      end
      n_checks++;
      if (p !== exp_p[i]) begin
        n_fail++;
        $display("FAIL product[%0d]: %h*%h got %h required %h", i, va[i], vb[i], p, exp_p[i]);
      end
      take_result();
      n_checks++;
      if ({start_ready, busy, res_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL handshake_idle[%0d]: rdy/busy/vld=%b required 100", i,
                 {start_ready, busy, res_valid});
      end
    end
  endtask

  task automatic test_sharing();
    int k;
    ex_alucontrol = ALU_SUB;
    ex_rs1 = 32'd10;
    ex_rs2 = 32'd3;
    #1;
    n_checks++;
    if (alu_alucontrol !== ALU_SUB || alu_rs1 !== 32'd10 || alu_rs2 !== 32'd3 ||
        alu_result !== 32'd7) begin
      n_fail++;
      $display("FAIL idle_passthru: op=%h rs1=%0d rs2=%0d res=%0d required %h 10 3 7",
               alu_alucontrol, alu_rs1, alu_rs2, alu_result, ALU_SUB);
    end
    @(negedge clk);
    start_valid = 1'b1;
    op_a = 32'd1234;
    op_b = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 40) begin
      ex_alucontrol = 4'($urandom_range(1, 15));
      ex_rs1 = $urandom;
      ex_rs2 = $urandom;
      #1;
      n_checks++;
      if (alu_alucontrol !== ALU_ADD || busy !== 1'b1 || alu_rs1 === ex_rs1 && alu_rs2 === ex_rs2) begin
        n_fail++;
        $display("FAIL run_owns_alu[%0d]: op=%h busy=%b required %h 1", k, alu_alucontrol, busy, ALU_ADD);
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    n_checks++;
    if ({res_hi, res_lo} !== 64'd1234 * 64'd5678) begin
      n_fail++;
      $display("FAIL share_product: got %h required %h", {res_hi, res_lo}, 64'd1234 * 64'd5678);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] p, held;
    logic [31:0] a, b;
    mul_op(32'hDEADBEEF, 32'h0000CAFE, lat, held);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || {res_hi, res_lo} !== held ||
          held !== 64'hDEADBEEF * 64'h0000CAFE) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b res=%h required 1 0 %h", i,
                 res_valid, start_ready, {res_hi, res_lo}, 64'hDEADBEEF * 64'h0000CAFE);
      end
    end
    start_valid = 1'b0;
    take_result();
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b busy=%b required 1 0", start_ready, busy);
    end
    a = $urandom;
    b = $urandom;
    mul_op(a, b, lat, p);
    n_checks++;
    if (p !== {32'd0, a} * {32'd0, b} || lat !== 32) begin
      n_fail++;
      $display("FAIL bp_next: got %h lat %0d required %h lat 32", p, lat, {32'd0, a} * {32'd0, b});
    end
    take_result();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [63:0] p;
    start_valid = 1'b1;
    op_a = 32'hFFFF1234;
    op_b = 32'h8765FFFF;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({start_ready, busy, res_valid} !== 3'b100 || {res_hi, res_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: rdy/busy/vld=%b res=%h required 100 / 0",
               {start_ready, busy, res_valid}, {res_hi, res_lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mul_op(32'd7, 32'd6, lat, p);
    n_checks++;
    if (p !== 64'd42 || lat !== 32) begin
      n_fail++;
      $display("FAIL after_reset_7x6: got %0d lat %0d required 42 lat 32", p, lat);
    end
    take_result();
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] p, exp_p;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      exp_p = {32'd0, a} * {32'd0, b};
      mul_op(a, b, lat, p);
      n_checks++;
      if (p !== exp_p || lat !== 32) begin
        n_fail++;
        $display("FAIL random[%0d]: %h*%h got %h lat %0d required %h lat 32", i, a, b, p, lat, exp_p);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_result();
    end
  endtask

  initial begin
    start_valid   = 1'b0;
    res_ready     = 1'b0;
    op_a          = '0;
    op_b          = '0;
    ex_alucontrol = ALU_ADD;
    ex_rs1        = '0;
    ex_rs2        = '0;
    test_reset();
    test_directed();
    test_sharing();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
